// File: rtl/bus_xfer_pkg.sv
// Shared types, sizes and helpers for the bus transfer sequencer.
package bus_xfer_pkg;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned REQ_W    = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  // Register index to one-hot register select.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Requester index to one-hot requester vector.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [REQ_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Requester arbiter. BUS_XFER_RR_EN selects round-robin starting at ptr;
// otherwise fixed priority, lowest index wins.
module rr_arbiter
  import bus_xfer_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifdef BUS_XFER_RR_EN
  input  logic [REQ_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_W-1:0]   grant_idx,
  output logic               any
);

  logic        found;
  int unsigned idx;

  // Scan requesters from the search start, first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef BUS_XFER_RR_EN
      idx = (32'(ptr) + i) % NUM_REQ;
`else
      idx = i;
`endif
      if (!found && req[REQ_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = REQ_W'(idx);
      end
    end
    if (found) begin
      grant = req_onehot(grant_idx);
    end
    any = found;
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Arbitrates register-to-register transfer requests and sequences the shared
// bus: DRIVE (source onto bus), WRITE (destination loads), DONE (pulse).
// Optional macro BUS_XFER_RR_EN: round-robin arbitration instead of fixed priority.
module bus_xfer_sequencer
  import bus_xfer_pkg::*;
(
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_src,
  input  logic [NUM_REQ*IDX_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REGS-1:0]      reg_out,
  output logic [NUM_REGS-1:0]      reg_in,
  output logic                     busy,
  output logic [REQ_W-1:0]         grant_id
);

  xfer_state_t         state, state_d;
  logic [IDX_W-1:0]    src_q, dst_q;
  logic [NUM_REQ-1:0]  win_grant;
  logic [REQ_W-1:0]    win_idx;
  logic                win_any;
  logic [IDX_W-1:0]    sel_src, sel_dst;
  logic                accept;
  logic [NUM_REGS-1:0] reg_out_d, reg_in_d;
  logic [NUM_REQ-1:0]  done_d;
  logic                busy_d;

`ifdef BUS_XFER_RR_EN
  logic [REQ_W-1:0] rr_ptr;

  // Round-robin pointer moves just past each accepted requester.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= REQ_W'((32'(win_idx) + 1) % NUM_REQ);
    end
  end
`endif

  rr_arbiter u_arb (
    .req       (req_valid),
`ifdef BUS_XFER_RR_EN
    .ptr       (rr_ptr),
`endif
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign sel_src = req_src[win_idx*IDX_W +: IDX_W];
  assign sel_dst = req_dst[win_idx*IDX_W +: IDX_W];

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, accept handshake and next values of the registered enables.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    accept    = 1'b0;
    reg_out_d = '0;
    reg_in_d  = '0;
    done_d    = '0;
    case (state)
      IDLE: begin
        if (win_any && clear) begin
          req_ready = win_grant;
          accept    = 1'b1;
          state_d   = DRIVE;
          reg_out_d = reg_onehot(sel_src);
        end
      end
      DRIVE: begin
        state_d   = WRITE;
        reg_out_d = reg_onehot(src_q);
        reg_in_d  = reg_onehot(dst_q);
      end
      WRITE: begin
        state_d = DONE;
        done_d  = req_onehot(grant_id);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Capture the winner's transfer so requesters may drop valid afterwards.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      src_q    <= '0;
      dst_q    <= '0;
      grant_id <= '0;
    end else if (accept) begin
      src_q    <= sel_src;
      dst_q    <= sel_dst;
      grant_id <= win_idx;
    end
  end

  // Registered bus selects, load enables, done pulse and busy flag.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      reg_out <= '0;
      reg_in  <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      reg_out <= reg_out_d;
      reg_in  <= reg_in_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench for bus_xfer_sequencer; follows BUS_XFER_RR_EN when defined.
module tb_bus_xfer_sequencer;
  import bus_xfer_pkg::*;

  logic        clock;
  logic        clear;
  logic [3:0]  req_valid;
  logic [15:0] req_src;
  logic [15:0] req_dst;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic [15:0] reg_out;
  logic [15:0] reg_in;
  logic        busy;
  logic [1:0]  grant_id;

  int total;
  int bad;

  bus_xfer_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .done      (done),
    .reg_out   (reg_out),
    .reg_in    (reg_in),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int k, input logic [3:0] s, input logic [3:0] d);
    req_src[k*4 +: 4] = s;
    req_dst[k*4 +: 4] = d;
  endtask

  task automatic do_reset;
    clear     = 1'b0;
    req_valid = 4'b0000;
    tick;
    tick;
    clear = 1'b1;
  endtask

  task automatic test_reset;
    clear     = 1'b0;
    req_valid = 4'b1111;
    req_src   = 16'h0000;
    req_dst   = 16'h0000;
    tick;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++;
    if (reg_out !== 16'h0000 || reg_in !== 16'h0000) begin bad++; $display("FAIL reset_enables got out=%h in=%h want 0000", reg_out, reg_in); end
    total++;
    if (done !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL reset_status got done=%b busy=%b gid=%0d want 0", done, busy, grant_id); end
    req_valid = 4'b0000;
    tick;
    clear = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    req_valid = 4'b0001;
    set_req(0, 4'd3, 4'd7);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    tick;
    req_valid = 4'b0000;
    #1;
    total++;
    if (reg_out !== 16'h0008 || reg_in !== 16'h0000 || busy !== 1'b1) begin bad++; $display("FAIL single_drive got out=%h in=%h busy=%b want 0008 0000 1", reg_out, reg_in, busy); end
    tick;
    #1;
    total++;
    if (reg_out !== 16'h0008 || reg_in !== 16'h0080) begin bad++; $display("FAIL single_write got out=%h in=%h want 0008 0080", reg_out, reg_in); end
    tick;
    #1;
    total++;
    if (done !== 4'b0001 || reg_out !== 16'h0000 || reg_in !== 16'h0000) begin bad++; $display("FAIL single_done got done=%b out=%h in=%h want 0001 0000 0000", done, reg_out, reg_in); end
    tick;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 4'b0000) begin bad++; $display("FAIL single_idle got busy=%b done=%b want 0 0000", busy, done); end
  endtask

  task automatic test_contention;
    logic [1:0]  exp;
    logic [3:0]  want_rdy;
    logic [15:0] want_out;
    do_reset;
    for (int k = 0; k < 4; k++) set_req(k, 4'(k), 4'(k + 8));
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
`ifdef BUS_XFER_RR_EN
      exp = 2'(n % 4);
`else
      exp = 2'd0;
`endif
      want_rdy = 4'b0001 << exp;
      want_out = 16'h0001 << exp;
      #1;
      total++;
      if (req_ready !== want_rdy) begin bad++; $display("FAIL contend_ready[%0d] got=%b want=%b", n, req_ready, want_rdy); end
      tick;
      #1;
      total++;
      if (grant_id !== exp || reg_out !== want_out) begin bad++; $display("FAIL contend_grant[%0d] got gid=%0d out=%h want %0d %h", n, grant_id, reg_out, exp, want_out); end
      tick;
      tick;
      tick;
    end
    req_valid = 4'b0000;
    tick;
  endtask

  task automatic test_same_reg;
    do_reset;
    req_valid = 4'b0001;
    set_req(0, 4'd5, 4'd5);
    tick;
    req_valid = 4'b0000;
    tick;
    #1;
    total++;
    if (reg_out !== 16'h0020 || reg_in !== 16'h0020) begin bad++; $display("FAIL same_write got out=%h in=%h want 0020 0020", reg_out, reg_in); end
    tick;
    #1;
    total++;
    if (done !== 4'b0001) begin bad++; $display("FAIL same_done got=%b want=0001", done); end
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0010;
    set_req(1, 4'd2, 4'd9);
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_ready got=%b want=0010", req_ready); end
    tick;
    tick;
    #1;
    total++;
    if (reg_in !== 16'h0200) begin bad++; $display("FAIL mid_write got in=%h want 0200", reg_in); end
    clear = 1'b0;
    #1;
    total++;
    if (reg_in !== 16'h0000 || reg_out !== 16'h0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL mid_abort got in=%h out=%h busy=%b rdy=%b want all 0", reg_in, reg_out, busy, req_ready); end
    tick;
    #1;
    total++;
    if (done !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL mid_nodone got done=%b busy=%b want 0000 0", done, busy); end
    tick;
    clear = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_reaccept got=%b want=0010", req_ready); end
    tick;
    #1;
    total++;
    if (reg_out !== 16'h0004 || grant_id !== 2'd1) begin bad++; $display("FAIL mid_redrive got out=%h gid=%0d want 0004 1", reg_out, grant_id); end
    req_valid = 4'b0000;
    tick;
    tick;
    tick;
  endtask

  task automatic test_late_request;
    do_reset;
    req_valid = 4'b0001;
    set_req(0, 4'd1, 4'd2);
    set_req(2, 4'd4, 4'd11);
    tick;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL late_drive_ready got=%b want=0000", req_ready); end
    tick;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL late_write_ready got=%b want=0000", req_ready); end
    tick;
    #1;
    total++;
    if (req_ready !== 4'b0000 || done !== 4'b0001) begin bad++; $display("FAIL late_done got rdy=%b done=%b want 0000 0001", req_ready, done); end
    tick;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL late_idle_ready got=%b want=0100", req_ready); end
    tick;
    req_valid = 4'b0000;
    #1;
    total++;
    if (grant_id !== 2'd2 || reg_out !== 16'h0010) begin bad++; $display("FAIL late_grant got gid=%0d out=%h want 2 0010", grant_id, reg_out); end
    tick;
    tick;
    tick;
  endtask

  task automatic test_onehot_random;
    do_reset;
    for (int n = 0; n < 1000; n++) begin
      req_valid = 4'($urandom);
      req_src   = 16'($urandom);
      req_dst   = 16'($urandom);
      #1;
      total++;
      if ($countones(reg_out) > 1 || $countones(reg_in) > 1) begin bad++; $display("FAIL onehot_enables[%0d] got out=%h in=%h want <=1 bit", n, reg_out, reg_in); end
      total++;
      if ($countones(done) > 1 || $countones(req_ready) > 1) begin bad++; $display("FAIL onehot_handshake[%0d] got done=%b rdy=%b want <=1 bit", n, done, req_ready); end
      tick;
    end
    req_valid = 4'b0000;
    tick;
    tick;
    tick;
    tick;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    clear     = 1'b0;
    req_valid = 4'b0000;
    req_src   = 16'h0000;
    req_dst   = 16'h0000;
    test_reset;
    test_single;
    test_contention;
    test_same_reg;
    test_reset_mid;
    test_late_request;
    test_onehot_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
